// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch squash.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_ctrl_stage #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          regwrite_i,
  input  logic          alusrc_i,
  input  logic          regdst_i,
  input  logic          branch_i,
  input  logic          memread_i,
  input  logic          memwrite_i,
  input  logic          memtoreg_i,
  input  logic [2:0]    aluop_i,
  input  logic [1:0]    branch_type_i,
  input  logic [4:0]    rs_i,
  input  logic [4:0]    rt_i,
  input  logic [4:0]    rd_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [DW-1:0] pc4_i,
  input  logic          flush_i,
  output logic          pc_write_o,
  output logic          ifid_write_o,
  output logic          ex_regwrite_o,
  output logic          ex_alusrc_o,
  output logic          ex_regdst_o,
  output logic          ex_branch_o,
  output logic          ex_memread_o,
  output logic          ex_memwrite_o,
  output logic          ex_memtoreg_o,
  output logic [2:0]    ex_aluop_o,
  output logic [1:0]    ex_branch_type_o,
  output logic          ex_valid_o,
  output logic [4:0]    ex_rs_o,
  output logic [4:0]    ex_rt_o,
  output logic [4:0]    ex_rd_o,
  output logic [DW-1:0] ex_rs_data_o,
  output logic [DW-1:0] ex_rt_data_o,
  output logic [DW-1:0] ex_imm_o,
  output logic [DW-1:0] ex_pc4_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   flush_cnt_o
`endif
);

  logic hz;
  logic stall;
  logic rt_used;

  // rt is a real source for R-type ops (alusrc=0) and as store data (memwrite=1).
  assign rt_used = !alusrc_i || memwrite_i;

  always_comb begin
    hz = 1'b0;
    if (ex_memread_o && (ex_rt_o != 5'd0)) begin
      hz = (ex_rt_o == rs_i) || ((ex_rt_o == rt_i) && rt_used);
    end
  end

  // A taken branch overrides the stall so the target fetch is not held.
  assign stall        = hz && !flush_i;
  assign pc_write_o   = !stall;
  assign ifid_write_o = !stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_regwrite_o    <= 1'b0;
      ex_alusrc_o      <= 1'b0;
      ex_regdst_o      <= 1'b0;
      ex_branch_o      <= 1'b0;
      ex_memread_o     <= 1'b0;
      ex_memwrite_o    <= 1'b0;
      ex_memtoreg_o    <= 1'b0;
      ex_aluop_o       <= 3'b000;
      ex_branch_type_o <= 2'b00;
      ex_valid_o       <= 1'b0;
      ex_rs_o          <= 5'd0;
      ex_rt_o          <= 5'd0;
      ex_rd_o          <= 5'd0;
      ex_rs_data_o     <= '0;
      ex_rt_data_o     <= '0;
      ex_imm_o         <= '0;
      ex_pc4_o         <= '0;
    end else begin
      // Datapath fields load unconditionally; ex_valid_o qualifies them.
      ex_rs_o      <= rs_i;
      ex_rt_o      <= rt_i;
      ex_rd_o      <= rd_i;
      ex_rs_data_o <= rs_data_i;
      ex_rt_data_o <= rt_data_i;
      ex_imm_o     <= imm_i;
      ex_pc4_o     <= pc4_i;
      if (flush_i || hz) begin
        ex_regwrite_o    <= 1'b0;
        ex_alusrc_o      <= 1'b0;
        ex_regdst_o      <= 1'b0;
        ex_branch_o      <= 1'b0;
        ex_memread_o     <= 1'b0;
        ex_memwrite_o    <= 1'b0;
        ex_memtoreg_o    <= 1'b0;
        ex_aluop_o       <= 3'b000;
        ex_branch_type_o <= 2'b00;
        ex_valid_o       <= 1'b0;
      end else begin
        ex_regwrite_o    <= regwrite_i;
        ex_alusrc_o      <= alusrc_i;
        ex_regdst_o      <= regdst_i;
        ex_branch_o      <= branch_i;
        ex_memread_o     <= memread_i;
        ex_memwrite_o    <= memwrite_i;
        ex_memtoreg_o    <= memtoreg_i;
        ex_aluop_o       <= aluop_i;
        ex_branch_type_o <= branch_type_i;
        ex_valid_o       <= 1'b1;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Saturating counters; a flush edge never counts as a stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (stall && (stall_cnt_o != 32'hFFFF_FFFF)) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && (flush_cnt_o != 32'hFFFF_FFFF)) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Self-checking bench for id_ex_ctrl_stage: reset, vector table, reset mid-stall.
module tb_id_ex_ctrl_stage;
  localparam int DW = 32;
  localparam int EW = 13 + 15 + 4 * DW;
  localparam int NV = 19;

  logic          clk, rst;
  logic          regwrite, alusrc, regdst, branch, memread, memwrite, memtoreg;
  logic [2:0]    aluop;
  logic [1:0]    branch_type;
  logic [4:0]    rs, rt, rd;
  logic [DW-1:0] rs_data, rt_data, imm, pc4;
  logic          flush;
  logic          pc_write, ifid_write;
  logic          ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg;
  logic [2:0]    ex_aluop;
  logic [1:0]    ex_branch_type;
  logic          ex_valid;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  id_ex_ctrl_stage #(.DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .regwrite_i(regwrite), .alusrc_i(alusrc), .regdst_i(regdst), .branch_i(branch),
    .memread_i(memread), .memwrite_i(memwrite), .memtoreg_i(memtoreg),
    .aluop_i(aluop), .branch_type_i(branch_type),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm), .pc4_i(pc4),
    .flush_i(flush),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .ex_regwrite_o(ex_regwrite), .ex_alusrc_o(ex_alusrc), .ex_regdst_o(ex_regdst),
    .ex_branch_o(ex_branch), .ex_memread_o(ex_memread), .ex_memwrite_o(ex_memwrite),
    .ex_memtoreg_o(ex_memtoreg), .ex_aluop_o(ex_aluop), .ex_branch_type_o(ex_branch_type),
    .ex_valid_o(ex_valid),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data), .ex_imm_o(ex_imm), .ex_pc4_o(ex_pc4)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rw, als, rdst, br, mr, mw, mtr;
    logic [2:0] aluop;
    logic [1:0] bt;
    logic [4:0] rs, rt, rd;
    logic [DW-1:0] imm;
    logic fl;
    logic exp_en;
    logic exp_bub;
  } vec_t;

  vec_t vecs[NV];
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int stall_m = 0;
  int flush_m = 0;

  function automatic vec_t mkv(input logic rw_a, input logic als_a, input logic mr_a,
                               input logic mw_a, input logic br_a, input logic [1:0] bt_a,
                               input logic [2:0] op_a, input logic [4:0] rs_a,
                               input logic [4:0] rt_a, input logic [4:0] rd_a,
                               input logic [DW-1:0] imm_a, input logic fl_a,
                               input logic en_a, input logic bub_a);
    vec_t v;
    v.rw = rw_a; v.als = als_a; v.rdst = !als_a; v.br = br_a; v.mr = mr_a;
    v.mw = mw_a; v.mtr = mr_a; v.aluop = op_a; v.bt = bt_a;
    v.rs = rs_a; v.rt = rt_a; v.rd = rd_a; v.imm = imm_a; v.fl = fl_a;
    v.exp_en = en_a; v.exp_bub = bub_a;
    return v;
  endfunction

  function automatic logic [EW-1:0] actual_ex();
    return {ex_regwrite, ex_alusrc, ex_regdst, ex_branch, ex_memread, ex_memwrite, ex_memtoreg,
            ex_aluop, ex_branch_type, ex_valid, ex_rs, ex_rt, ex_rd,
            ex_rs_data, ex_rt_data, ex_imm, ex_pc4};
  endfunction

  // Expected EX contents built from the driven inputs and the expected bubble flag
  function automatic logic [EW-1:0] expected_ex(input vec_t v);
    logic [12:0] c;
    if (v.exp_bub) c = 13'd0;
    else c = {v.rw, v.als, v.rdst, v.br, v.mr, v.mw, v.mtr, v.aluop, v.bt, 1'b1};
    return {c, v.rs, v.rt, v.rd, rs_data, rt_data, v.imm, pc4};
  endfunction

  // Driver tasks
  task automatic set_inputs(input vec_t v);
    regwrite = v.rw; alusrc = v.als; regdst = v.rdst; branch = v.br;
    memread = v.mr; memwrite = v.mw; memtoreg = v.mtr;
    aluop = v.aluop; branch_type = v.bt;
    rs = v.rs; rt = v.rt; rd = v.rd; imm = v.imm; flush = v.fl;
    rs_data = $urandom; rt_data = $urandom; pc4 = DW'($urandom_range(0, 65535)) << 2;
  endtask

  task automatic check_en(input string name, input logic exp_en);
    checks++;
    if (pc_write !== exp_en || ifid_write !== exp_en) begin
      errors++;
      $display("FAIL %s: pc_write=%b ifid_write=%b expected %b", name, pc_write, ifid_write, exp_en);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'(stall_m) || flush_cnt !== 32'(flush_m)) begin
      errors++;
      $display("FAIL %s cnt: stall=%0d flush=%0d expected stall=%0d flush=%0d",
               name, stall_cnt, flush_cnt, stall_m, flush_m);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // Scoreboard: push when the vector is driven, pop after the edge
  task automatic edge_and_check(input string name, input vec_t v);
    logic [EW-1:0] e;
    exp_q.push_back(expected_ex(v));
    if (v.exp_bub && !v.fl) stall_m++;
    if (v.fl) flush_m++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (actual_ex() !== e) begin
      errors++;
      $display("FAIL %s ex: got %h expected %h", name, actual_ex(), e);
    end
    check_cnt(name);
  endtask

  task automatic drive_vec(input string name, input vec_t v);
    set_inputs(v);
    #3;
    check_en(name, v.exp_en);
    edge_and_check(name, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = mkv(1,1,0,0,0,2'd0,3'd0,  2, 3, 0, 5,          0, 1,0); // addi
    vecs[1]  = mkv(1,1,1,0,0,2'd0,3'd0,  1, 8, 0, 4,          0, 1,0); // lw rt8
    vecs[2]  = mkv(1,0,0,0,0,2'd0,3'd2,  8, 4, 5, 0,          0, 0,1); // R rs8 stall
    vecs[3]  = mkv(1,0,0,0,0,2'd0,3'd2,  8, 4, 5, 0,          0, 1,0); // R enters
    vecs[4]  = mkv(1,1,1,0,0,2'd0,3'd0,  1, 0, 0, 8,          0, 1,0); // lw rt0
    vecs[5]  = mkv(1,0,0,0,0,2'd0,3'd2,  0, 0, 6, 0,          0, 1,0); // R rs0: no stall
    vecs[6]  = mkv(1,1,1,0,0,2'd0,3'd0,  2, 9, 0, 12,         0, 1,0); // lw rt9
    vecs[7]  = mkv(1,1,0,0,0,2'd0,3'd0,  1, 9, 0, 7,          0, 1,0); // addi rt9: no stall
    vecs[8]  = mkv(1,1,1,0,0,2'd0,3'd0,  2, 9, 0, 12,         0, 1,0); // lw rt9
    vecs[9]  = mkv(0,1,0,1,0,2'd0,3'd0,  1, 9, 0, 16,         0, 0,1); // sw rt9 stall
    vecs[10] = mkv(0,1,0,1,0,2'd0,3'd0,  1, 9, 0, 16,         0, 1,0); // sw enters
    vecs[11] = mkv(1,1,1,0,0,2'd0,3'd0,  3, 7, 0, 20,         0, 1,0); // lw rt7
    vecs[12] = mkv(1,0,0,0,0,2'd0,3'd2,  7, 2, 3, 0,          1, 1,1); // hazard + flush
    vecs[13] = mkv(0,0,0,0,1,2'd3,3'd1,  3, 4, 0, 32'hFFFF_FFFC, 0, 1,0); // bgt
    vecs[14] = mkv(0,0,0,0,1,2'd0,3'd1,  5, 6, 0, 8,          1, 1,1); // flush alone
    vecs[15] = mkv(1,1,1,0,0,2'd0,3'd0,  1, 6, 0, 0,          0, 1,0); // lw rt6
    vecs[16] = mkv(1,0,0,0,0,2'd0,3'd2,  1, 6, 10, 0,         0, 0,1); // R rt6 stall
    vecs[17] = mkv(1,0,0,0,0,2'd0,3'd2,  1, 6, 10, 0,         0, 1,0); // R enters
    vecs[18] = mkv(0,0,0,0,1,2'd1,3'd1, 10, 11, 0, 3,         0, 1,0); // bne

    // Reset asserted mid-cycle with all inputs high and EX non-zero
    rst = 1'b1;
    v = mkv(1,1,1,1,1,2'd3,3'd7, 31,31,31, '1, 0, 1,0);
    set_inputs(v);
    rs_data = '1; rt_data = '1; pc4 = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (actual_ex() !== '0) begin
      errors++;
      $display("FAIL reset ex: got %h expected 0", actual_ex());
    end
    check_en("reset", 1'b1);
    check_cnt("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) drive_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset during a stall: the stall drops at once, next edge loads normally
    drive_vec("rst_lw", vecs[1]);
    v = vecs[2];
    set_inputs(v);
    #2;
    check_en("pre_rst_stall", 1'b0);
    rst = 1'b1;
    #1;
    check_en("rst_mid_stall", 1'b1);
    checks++;
    if (ex_valid !== 1'b0 || ex_memread !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall ex: valid=%b memread=%b expected 0 0", ex_valid, ex_memread);
    end
    stall_m = 0;
    flush_m = 0;
    #1 rst = 1'b0;
    v.exp_bub = 1'b0;
    edge_and_check("post_rst_load", v);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
